// File: rtl/match_arbiter.sv
// rtl/match_arbiter.sv - round-robin match arbiter and session sequencer for the trade counter
module match_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int QUOTA        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_halt_in,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_grant_id,
    output logic             o_match_signal,
    output logic             o_enable_count,
    output logic [7:0]       o_grants_total,
    output logic [1:0]       o_state,
    output logic             o_session_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [7:0]      QUOTA_L = 8'(QUOTA);
    localparam logic [7:0]      DRAIN_L = 8'(DRAIN_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [7:0]      r_cnt [N_REQ];
    logic [7:0]      r_drain;

    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_next_ptr;
    logic [N_REQ-1:0] w_onehot;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = i_req[i] && ((QUOTA == 0) || (r_cnt[i] < QUOTA_L));
        end
    end

    // First eligible requester at or above the pointer, wrapping round.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_next_ptr = (w_win == LAST_ID) ? '0 : w_win + 1'b1;
    assign w_onehot   = N_REQ'(1) << w_win;
    assign o_state    = r_state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_drain        <= '0;
            o_gnt          <= '0;
            o_grant_id     <= '0;
            o_match_signal <= 1'b0;
            o_enable_count <= 1'b0;
            o_grants_total <= '0;
            o_session_done <= 1'b0;
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
        end else begin
            o_gnt          <= '0;
            o_match_signal <= 1'b0;
            o_session_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    o_enable_count <= 1'b0;
                    if (i_start) begin
                        r_state        <= ST_RUN;
                        o_enable_count <= 1'b1;
                        o_grants_total <= '0;
                        r_ptr          <= '0;
                        for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
                    end
                end
                ST_RUN: begin
                    if (i_halt_in) begin
                        r_state        <= ST_HALTED;
                        o_enable_count <= 1'b0;
                    end else if (i_stop) begin
                        r_state <= ST_DRAIN;
                        r_drain <= DRAIN_L;
                    end else if (w_found) begin
                        o_gnt          <= w_onehot;
                        o_match_signal <= 1'b1;
                        o_grant_id     <= w_win;
                        r_ptr          <= w_next_ptr;
                        if (r_cnt[w_win] != 8'hFF) r_cnt[w_win] <= r_cnt[w_win] + 8'd1;
                        if (o_grants_total != 8'hFF) o_grants_total <= o_grants_total + 8'd1;
                    end
                end
                // Keep the counter enabled long enough to register an in-flight match.
                ST_DRAIN: begin
                    if (i_halt_in) begin
                        r_state        <= ST_HALTED;
                        o_enable_count <= 1'b0;
                    end else if (r_drain == 8'd0) begin
                        r_state        <= ST_IDLE;
                        o_enable_count <= 1'b0;
                        o_session_done <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 8'd1;
                    end
                end
                default: begin
                    o_enable_count <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_arbiter.sv
// tb/tb_match_arbiter.sv - directed scoreboard bench for match_arbiter
module tb_match_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] req;
    logic       halt_in;
    logic [3:0] gnt;
    logic [1:0] grant_id;
    logic       match_signal;
    logic       enable_count;
    logic [7:0] grants_total;
    logic [1:0] state;
    logic       session_done;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q [$];
    logic [3:0] exp_gnt;

    match_arbiter #(.N_REQ(4), .ID_W(2), .QUOTA(8), .DRAIN_CYCLES(2)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_stop         (stop),
        .i_req          (req),
        .i_halt_in      (halt_in),
        .o_gnt          (gnt),
        .o_grant_id     (grant_id),
        .o_match_signal (match_signal),
        .o_enable_count (enable_count),
        .o_grants_total (grants_total),
        .o_state        (state),
        .o_session_done (session_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the expectation pushed when the stimulus was driven and compares grant outputs.
    task automatic tick_gnt(input string tag);
        tick();
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            exp_gnt = exp_q.pop_front();
            chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
            chk({tag, "_match"}, 32'(match_signal), 32'(|exp_gnt));
            if (exp_gnt != 4'b0000) begin
                chk({tag, "_id"}, 32'(grant_id), 32'($clog2(exp_gnt)));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_match"}, 32'(match_signal), 32'd0);
        chk({tag, "_en"}, 32'(enable_count), 32'd0);
        chk({tag, "_total"}, 32'(grants_total), 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_done"}, 32'(session_done), 32'd0);
    endtask

    initial begin
        logic [3:0] rr [4];
        rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100; rr[3] = 4'b1000;
        reset = 1'b1; start = 1'b0; stop = 1'b0; req = 4'b0000; halt_in = 1'b0;
        #1;
        chk_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd0);

        // stop in IDLE is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_ignored", 32'(state), 32'd0);

        // 1: round robin over four requesters
        start = 1'b1; req = 4'b1111;
        tick();
        start = 1'b0;
        chk("t1_state_run", 32'(state), 32'd1);
        chk("t1_en", 32'(enable_count), 32'd1);
        chk("t1_no_gnt_on_start", 32'(gnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(rr[i % 4]);
            tick_gnt("t1");
        end
        chk("t1_total", 32'(grants_total), 32'd8);
        req = 4'b0000;
        exp_q.push_back(4'b0000);
        tick_gnt("t1_idle_req");

        // 3: stop closes the session through DRAIN
        req = 4'b0101;
        exp_q.push_back(4'b0001);
        tick_gnt("t3_a");
        exp_q.push_back(4'b0100);
        tick_gnt("t3_b");
        chk("t3_total", 32'(grants_total), 32'd10);
        stop = 1'b1;
        exp_q.push_back(4'b0000);
        tick_gnt("t3_stop");
        stop = 1'b0;
        chk("t3_drain_state", 32'(state), 32'd2);
        chk("t3_drain_en1", 32'(enable_count), 32'd1);
        chk("t3_done_lo1", 32'(session_done), 32'd0);
        exp_q.push_back(4'b0000);
        tick_gnt("t3_drain2");
        chk("t3_drain_en2", 32'(enable_count), 32'd1);
        chk("t3_drain_state2", 32'(state), 32'd2);
        tick();
        chk("t3_idle_state", 32'(state), 32'd0);
        chk("t3_en_off", 32'(enable_count), 32'd0);
        chk("t3_done_pulse", 32'(session_done), 32'd1);
        chk("t3_gnt_off", 32'(gnt), 32'd0);
        tick();
        chk("t3_done_cleared", 32'(session_done), 32'd0);

        // 2: quota masks a lone requester after 8 grants
        req = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_total_cleared", 32'(grants_total), 32'd0);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(i < 8 ? 4'b0001 : 4'b0000);
            tick_gnt("t2");
        end
        chk("t2_total", 32'(grants_total), 32'd8);
        chk("t2_still_run", 32'(state), 32'd1);

        // 4: halt preempts grants and is terminal
        req = 4'b1111;
        exp_q.push_back(4'b0010);
        tick_gnt("t4_pre");
        halt_in = 1'b1;
        exp_q.push_back(4'b0000);
        tick_gnt("t4_halt");
        halt_in = 1'b0;
        chk("t4_state", 32'(state), 32'd3);
        chk("t4_en", 32'(enable_count), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_start_ignored", 32'(state), 32'd3);
        chk("t4_gnt_low", 32'(gnt), 32'd0);
        req = 4'b0000;

        #2 reset = 1'b1;
        #1 reset = 1'b0;
        chk("t5_pre_state", 32'(state), 32'd0);

        // 5: halt beats stop at the same edge
        start = 1'b1; req = 4'b1111;
        tick();
        start = 1'b0;
        exp_q.push_back(4'b0001);
        tick_gnt("t5_pre");
        halt_in = 1'b1; stop = 1'b1;
        tick();
        halt_in = 1'b0; stop = 1'b0;
        chk("t5_state", 32'(state), 32'd3);
        chk("t5_gnt", 32'(gnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_done", 32'(session_done), 32'd0);
        end
        chk("t5_state_hold", 32'(state), 32'd3);

        // 6: asynchronous reset drops a pending grant
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        start = 1'b1; req = 4'b1111;
        tick();
        start = 1'b0;
        exp_q.push_back(4'b0001);
        tick_gnt("t6_a");
        exp_q.push_back(4'b0010);
        tick_gnt("t6_b");
        exp_q.push_back(4'b0100);
        tick_gnt("t6_c");
        #2 reset = 1'b1;
        #1;
        chk_all_zero("t6_async");
        tick();
        reset = 1'b0;
        req = 4'b1000; start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(4'b1000);
        tick_gnt("t6_after");
        chk("t6_total", 32'(grants_total), 32'd1);
        chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
